// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM duty-capture block: state encoding, widths,
// the generator-compatible prescaler default and small saturation helpers.
package pwm_capture_pkg;

    // Widths of the reported duty and period values.
    localparam int DUTY_W   = 8;
    localparam int PERIOD_W = 9;

    // Prescaler terminal count shared with the PWM generator (3.9 us at 50 MHz).
    localparam logic [7:0]          SEGMENT_DEFAULT    = 8'd195;

    // Period saturation / no-edge timeout, in sample ticks.
    localparam logic [PERIOD_W-1:0] PERIOD_MAX_DEFAULT = 9'd511;

    // The high-tick counter always saturates at its full 9-bit range.
    localparam logic [PERIOD_W-1:0] HIGH_CNT_MAX       = 9'd511;

    // Largest reportable duty.
    localparam logic [DUTY_W-1:0]   DUTY_MAX           = 8'd255;

    // Capture states: SYNC waits for the first edge, MEASURE counts between
    // rising edges, STUCK holds the timeout report until the line moves again.
    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } cap_state_t;

    // Add a single bit to a counter, pinning it at the given limit.
    function automatic logic [PERIOD_W-1:0] sat_add(
        input logic [PERIOD_W-1:0] value,
        input logic                inc,
        input logic [PERIOD_W-1:0] limit
    );
        if (value >= limit) begin
            return limit;
        end
        return value + {{(PERIOD_W-1){1'b0}}, inc};
    endfunction

    // Reduce a 9-bit high-tick count to the 8-bit duty scale.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [PERIOD_W-1:0] value);
        if (value > {1'b0, DUTY_MAX}) begin
            return DUTY_MAX;
        end
        return value[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_in_sampler.sv
// Input front end for pwm_duty_capture: 2-flop synchronizer, SEGMENT
// prescaler generating the sample tick, and rising-edge detection on the
// sampled level.
// Optional macro PWM_GLITCH_FILTER_EN: the sampled level becomes the majority
// of the last three raw samples, rejecting single-tick pulses of either polarity.
module pwm_in_sampler
    import pwm_capture_pkg::*;
#(
    parameter logic [7:0] SEGMENT = SEGMENT_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic PWM_In,
    output logic tick,
    output logic sample,
    output logic rise
);

    logic       sync_1;
    logic       sync_2;
    logic [7:0] c1;
    logic       prev_sample;

    // Two-flop synchronizer bringing the asynchronous PWM line into CLK.
    // NOTE: non-blocking assignments make sync_2 take the old sync_1, giving
    // the two distinct flop stages; blocking here would collapse them into one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= PWM_In;
            sync_2 <= sync_1;
        end
    end

    // Prescaler: counts 0..SEGMENT and wraps; the terminal cycle is the tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            c1 <= 8'd0;
        end else if (c1 == SEGMENT) begin
            c1 <= 8'd0;
        end else begin
            c1 <= c1 + 8'd1;
        end
    end

    assign tick = (c1 == SEGMENT);

`ifdef PWM_GLITCH_FILTER_EN
    // raw_hist[0] is the previous raw sample, raw_hist[1] the one before it.
    logic [1:0] raw_hist;

    // Raw-sample history for the 3-tick majority vote.
    always_ff @(posedge CLK) begin
        if (RST) begin
            raw_hist <= 2'b00;
        end else if (tick) begin
            raw_hist <= {raw_hist[0], sync_2};
        end
    end

    assign sample = (sync_2 & raw_hist[0]) |
                    (sync_2 & raw_hist[1]) |
                    (raw_hist[0] & raw_hist[1]);
`else
    assign sample = sync_2;
`endif

    // Previous sampled level, used for rising-edge detection on each tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_sample <= 1'b0;
        end else if (tick) begin
            prev_sample <= sample;
        end
    end

    assign rise = tick & sample & ~prev_sample;

endmodule

// File: rtl/pwm_duty_capture.sv
// PWM duty capture: measures an incoming PWM waveform on the generator's
// SEGMENT time base and reports duty (high ticks, 1/256 scale), period
// between rising edges, a one-CLK update strobe and a stuck-line flag.
// Optional macro PWM_GLITCH_FILTER_EN enables a 3-tick majority filter in
// the input sampler.
module pwm_duty_capture
    import pwm_capture_pkg::*;
#(
    parameter logic [7:0]          SEGMENT    = SEGMENT_DEFAULT,
    parameter logic [PERIOD_W-1:0] PERIOD_MAX = PERIOD_MAX_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PWM_In,
    output logic [DUTY_W-1:0]   Duty_Out,
    output logic [PERIOD_W-1:0] Period_Out,
    output logic                Valid_Out,
    output logic                Stuck_Out
);

    logic tick;
    logic sample;
    logic rise;

    cap_state_t          state;
    cap_state_t          state_nxt;
    logic [PERIOD_W-1:0] period_cnt;
    logic [PERIOD_W-1:0] period_cnt_nxt;
    logic [PERIOD_W-1:0] high_cnt;
    logic [PERIOD_W-1:0] high_cnt_nxt;
    logic [PERIOD_W-1:0] period_inc;
    logic [DUTY_W-1:0]   duty_nxt;
    logic [PERIOD_W-1:0] period_out_nxt;
    logic                valid_nxt;
    logic                stuck_nxt;

    pwm_in_sampler #(
        .SEGMENT (SEGMENT)
    ) u_sampler (
        .CLK    (CLK),
        .RST    (RST),
        .PWM_In (PWM_In),
        .tick   (tick),
        .sample (sample),
        .rise   (rise)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter and report logic; only tick cycles change anything.
    always_comb begin
        // NOTE: every target gets a hold/default value first so no path through
        // the case leaves it unassigned, which would otherwise infer a latch.
        state_nxt      = state;
        period_cnt_nxt = period_cnt;
        high_cnt_nxt   = high_cnt;
        duty_nxt       = Duty_Out;
        period_out_nxt = Period_Out;
        stuck_nxt      = Stuck_Out;
        valid_nxt      = 1'b0;
        period_inc     = sat_add(period_cnt, 1'b1, PERIOD_MAX);

        if (tick) begin
            unique case (state)
                SYNC: begin
                    // Counts before the first edge are meaningless; just arm.
                    if (rise) begin
                        period_cnt_nxt = {{(PERIOD_W-1){1'b0}}, 1'b1};
                        high_cnt_nxt   = {{(PERIOD_W-1){1'b0}}, 1'b1};
                        state_nxt      = MEASURE;
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        // A full period just closed: publish it and restart.
                        duty_nxt       = clamp_duty(high_cnt);
                        period_out_nxt = period_cnt;
                        valid_nxt      = 1'b1;
                        period_cnt_nxt = {{(PERIOD_W-1){1'b0}}, 1'b1};
                        high_cnt_nxt   = {{(PERIOD_W-1){1'b0}}, 1'b1};
                    end else begin
                        period_cnt_nxt = period_inc;
                        high_cnt_nxt   = sat_add(high_cnt, sample, HIGH_CNT_MAX);
                        if (period_inc == PERIOD_MAX) begin
                            // No edge for the whole timeout: report the static level.
                            duty_nxt       = sample ? DUTY_MAX : '0;
                            period_out_nxt = PERIOD_MAX;
                            stuck_nxt      = 1'b1;
                            valid_nxt      = 1'b1;
                            state_nxt      = STUCK;
                        end
                    end
                end

                STUCK: begin
                    // The edge that ends a stuck condition starts a new period
                    // but there is no complete period to report yet.
                    if (rise) begin
                        stuck_nxt      = 1'b0;
                        period_cnt_nxt = {{(PERIOD_W-1){1'b0}}, 1'b1};
                        high_cnt_nxt   = {{(PERIOD_W-1){1'b0}}, 1'b1};
                        state_nxt      = MEASURE;
                    end
                end

                default: begin
                    state_nxt = SYNC;
                end
            endcase
        end
    end

    // Counter and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            Duty_Out   <= '0;
            Period_Out <= '0;
            Valid_Out  <= 1'b0;
            Stuck_Out  <= 1'b0;
        end else begin
            period_cnt <= period_cnt_nxt;
            high_cnt   <= high_cnt_nxt;
            Duty_Out   <= duty_nxt;
            Period_Out <= period_out_nxt;
            Valid_Out  <= valid_nxt;
            Stuck_Out  <= stuck_nxt;
        end
    end

endmodule
